// File: rtl/config_pkg.sv
// rtl/config_pkg.sv - shared configuration types
package config_pkg;

    typedef logic [31:0] word;

endpackage

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared uart types and constants
package uart_pkg;

    localparam int DataBitsDefault = 8;

    // Right shift that turns a bit period into a half bit period.
    localparam int HalfBitShift = 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_IDLE
    } uart_rx_state_t;

endpackage

// File: rtl/sync_ff.sv
// rtl/sync_ff.sv - multi-stage synchronizer with reset value 1
module sync_ff #(
    parameter int Stages = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] ff;

    // Shift chain. Resets high so an idle serial line does not look like a start bit.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            ff <= '1;
        end else begin
            ff <= {ff[Stages-2:0], d};
        end
    end

    assign q = ff[Stages-1];

endmodule

// File: rtl/uart_rx.sv
// rtl/uart_rx.sv - 8N1 uart receiver with one-entry holding register
module uart_rx
    import uart_pkg::*;
    import config_pkg::*;
#(
    parameter int DataBits   = DataBitsDefault,
    parameter int SyncStages = 2
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [31:0]         prescaler,
    input  logic                rx,
    output logic [DataBits-1:0] d_out,
    output logic                d_valid,
    input  logic                d_ready,
    output logic                framing_err,
    output logic                overrun,
    output logic                busy
);

    localparam int IdxW = (DataBits > 1) ? $clog2(DataBits) : 1;

    uart_rx_state_t      state_q, state_d;
    word                 n_q, n_d;
    word                 cnt_q, cnt_d;
    word                 n_new;
    logic [IdxW-1:0]     idx_q, idx_d;
    logic [DataBits-1:0] shift_q, shift_d;
    logic                rx_s;
    logic                frame_good;
    logic                frame_bad;

    sync_ff #(
        .Stages (SyncStages)
    ) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d       (rx),
        .q       (rx_s)
    );

    // prescaler=0 would give a one-cycle bit with no half-bit point, so clamp to N=2.
    assign n_new = (prescaler == 32'd0) ? word'(2) : prescaler + word'(1);
    assign busy  = (state_q != IDLE);

    // Frame state, bit period, cycle counter, bit index and shift register.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            state_q <= IDLE;
            n_q     <= '0;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
        end else begin
            state_q <= state_d;
            n_q     <= n_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
        end
    end

    // Next-state logic; the counter reaching 1 marks a sampling point on rx_s.
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        shift_d    = shift_q;
        frame_good = 1'b0;
        frame_bad  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rx_s) begin
                    n_d     = n_new;
                    cnt_d   = n_new >> HalfBitShift;
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == word'(1)) begin
                    if (!rx_s) begin
                        idx_d   = '0;
                        cnt_d   = n_q;
                        state_d = DATA;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - word'(1);
                end
            end
            DATA: begin
                if (cnt_q == word'(1)) begin
                    shift_d = {rx_s, shift_q} >> 1;
                    cnt_d   = n_q;
                    if (idx_q == IdxW'(DataBits - 1)) begin
                        state_d = STOP;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - word'(1);
                end
            end
            STOP: begin
                if (cnt_q == word'(1)) begin
                    if (rx_s) begin
                        frame_good = 1'b1;
                        state_d    = IDLE;
                    end else begin
                        frame_bad = 1'b1;
                        state_d   = WAIT_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - word'(1);
                end
            end
            WAIT_IDLE: begin
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Holding register handshake plus one-cycle error pulses.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            d_out       <= '0;
            d_valid     <= 1'b0;
            framing_err <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            framing_err <= frame_bad;
            overrun     <= 1'b0;
            if (frame_good && (!d_valid || d_ready)) begin
                d_out   <= shift_q;
                d_valid <= 1'b1;
            end else begin
                if (frame_good) begin
                    overrun <= 1'b1;
                end
                if (d_valid && d_ready) begin
                    d_valid <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// tb/tb_uart_rx.sv - scoreboard testbench for uart_rx
module tb_uart_rx;

    logic        clk = 1'b0;
    logic        reset_i;
    logic [31:0] prescaler;
    logic        rx;
    logic [7:0]  d_out;
    logic        d_valid;
    logic        d_ready;
    logic        framing_err;
    logic        overrun;
    logic        busy;

    uart_rx dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .prescaler   (prescaler),
        .rx          (rx),
        .d_out       (d_out),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .framing_err (framing_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int vcnt   = 0;
    int t_fall = 0;
    int lat;
    int busy_cnt;
    int fe0, ov0, v0;
    logic [7:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted byte and counts flag pulses.
    always @(negedge clk) begin
        logic [7:0] e;
        if (reset_i) begin
            if (framing_err) fe_cnt++;
            if (overrun) ov_cnt++;
            if (d_valid) vcnt++;
            if (d_valid && d_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", d_out);
                end else begin
                    e = exp_q.pop_front();
                    check("d_out", {24'd0, d_out}, {24'd0, e});
                end
            end
        end
    end

    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int n);
        @(posedge clk); #1;
        rx = 1'b0;
        t_fall = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (n) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (n) @(posedge clk);
        #1 rx = stop_bit;
        repeat (n) @(posedge clk);
        if (!stop_bit) repeat (3 * n) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] b;
        reset_i   = 1'b0;
        rx        = 1'b1;
        d_ready   = 1'b0;
        prescaler = 32'd3;
        repeat (3) @(posedge clk);
        #1;
        check("reset_outputs", {19'd0, d_out, d_valid, framing_err, overrun, busy}, 32'd0);
        reset_i = 1'b1;
        repeat (5) @(posedge clk);

        // Single frame 0x41 at N=4: d_valid 41 cycles after the falling edge.
        d_ready = 1'b1;
        exp_q.push_back(8'h41);
        lat = -1;
        fork
            send_frame(8'h41, 1'b1, 4);
            begin
                for (int i = 0; i < 200; i++) begin
                    @(posedge clk); #1;
                    if (d_valid) begin
                        lat = cyc - t_fall;
                        break;
                    end
                end
            end
        join
        check("first_latency", lat, 41);
        repeat (5) @(posedge clk);
        check("t1_queue_empty", exp_q.size(), 0);
        check("t1_framing", fe_cnt, 0);
        check("t1_overrun", ov_cnt, 0);

        // Back-to-back stream, consumer always ready.
        exp_q.push_back(8'h41);
        exp_q.push_back(8'h42);
        exp_q.push_back(8'h43);
        send_frame(8'h41, 1'b1, 4);
        send_frame(8'h42, 1'b1, 4);
        send_frame(8'h43, 1'b1, 4);
        repeat (10) @(posedge clk);
        check("t2_queue_empty", exp_q.size(), 0);
        check("t2_flags", fe_cnt + ov_cnt, 0);

        // One-cycle glitch at N=8 is rejected in START.
        prescaler = 32'd7;
        v0 = vcnt;
        @(posedge clk); #1 rx = 1'b0;
        @(posedge clk); #1 rx = 1'b1;
        busy_cnt = 0;
        repeat (30) begin
            @(posedge clk); #1;
            if (busy) busy_cnt++;
        end
        check("glitch_busy_seen", busy_cnt > 0, 1);
        check("glitch_busy_max", busy_cnt <= 5, 1);
        check("glitch_idle", busy, 0);
        check("glitch_no_valid", vcnt - v0, 0);
        check("glitch_flags", fe_cnt + ov_cnt, 0);

        // Framing error on 0x55 followed by line break, then a good 0x43.
        prescaler = 32'd3;
        fe0 = fe_cnt;
        v0  = vcnt;
        send_frame(8'h55, 1'b0, 4);
        repeat (5) @(posedge clk);
        check("framing_pulse", fe_cnt - fe0, 1);
        check("framing_no_valid", vcnt - v0, 0);
        exp_q.push_back(8'h43);
        send_frame(8'h43, 1'b1, 4);
        repeat (5) @(posedge clk);
        check("t4_queue_empty", exp_q.size(), 0);
        check("t4_framing_once", fe_cnt - fe0, 1);

        // Overrun while stalled, then accept and new byte in the same cycle.
        d_ready = 1'b0;
        ov0 = ov_cnt;
        exp_q.push_back(8'h41);
        send_frame(8'h41, 1'b1, 4);
        send_frame(8'h42, 1'b1, 4);
        repeat (5) @(posedge clk);
        #1;
        check("ovr_hold_valid", d_valid, 1);
        check("ovr_hold_data", d_out, 8'h41);
        check("ovr_pulse", ov_cnt - ov0, 1);
        exp_q.push_back(8'h43);
        send_frame(8'h43, 1'b1, 4);
        d_ready = 1'b1;
        @(posedge clk); #1;
        check("ovr_swap_valid", d_valid, 1);
        check("ovr_swap_data", d_out, 8'h43);
        repeat (5) @(posedge clk);
        #1;
        check("t5_queue_empty", exp_q.size(), 0);
        check("t5_drained", d_valid, 0);
        check("t5_overrun_once", ov_cnt - ov0, 1);

        // Reset during data bit 4 of 0x41, then a clean 0x42.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        b = 8'h41;
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 5; i++) begin
            repeat (4) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (2) @(posedge clk);
        #1;
        reset_i = 1'b0;
        rx = 1'b1;
        #1;
        check("midframe_reset_outputs", {19'd0, d_out, d_valid, framing_err, overrun, busy}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b1;
        repeat (10) @(posedge clk);
        exp_q.push_back(8'h42);
        send_frame(8'h42, 1'b1, 4);
        repeat (5) @(posedge clk);
        check("t6_queue_empty", exp_q.size(), 0);
        check("t6_flags", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 8N1 UART receiver. Receive-side counterpart of the existing uart transmitter, using the same prescaler convention.
- Samples the asynchronous rx pin, reconstructs bytes LSB-first and presents each byte through a one-entry holding register with a valid/ready handshake.
- Flags framing errors and overruns.
- Sits between the board rx pin and a byte consumer (CSR-readable fifo or core).

Parameters:
- DataBits, 8, number of data bits per frame.
- SyncStages, 2, flip-flops in the rx input synchronizer (>=2).

Ports:
- clk_i  input  1  system clock.
- reset_i  input  1  asynchronous active-low reset.
- prescaler  input  32 (word)  bit period N = prescaler+1 clock cycles. Sampled at frame start; changes mid-frame are ignored.
- rx  input  1  serial line, idle high, asynchronous.
- d_out  output  DataBits  received byte, valid while d_valid=1.
- d_valid  output  1  holding register full.
- d_ready  input  1  consumer accepts d_out when d_valid&d_ready.
- framing_err  output  1  one-cycle pulse when the stop bit samples low.
- overrun  output  1  one-cycle pulse when a good frame completes while the holding register is full and not being drained.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (reset_i=0, async):
  - state=IDLE; d_out=0, d_valid=0, framing_err=0, overrun=0, busy=0.
  - Synchronizer flops preset to 1. Bit counter and shift register cleared.
  - Reset mid-frame abandons the frame; no pulse is emitted.
- Synchronizer: rx_s is rx delayed by SyncStages clocks. All logic uses rx_s only.
- State machine (UartRxStateT): IDLE, START, DATA, STOP, WAIT_IDLE.
  - IDLE: on rx_s==0, latch N=prescaler+1 and load the cycle counter to wait floor(N/2) cycles, then go to START.
  - START: when the counter expires, sample rx_s.
    - 0: bit index=0, reload counter to N, go to DATA.
    - 1: glitch; return to IDLE with no flags.
  - DATA: every N cycles, shift rx_s into the MSB of the shift register (LSB-first reception). After DataBits samples, reload N and go to STOP.
  - STOP: when the counter expires, sample rx_s.
    - 1: frame good, go to IDLE.
    - 0: framing_err pulses; data discarded; go to WAIT_IDLE.
  - WAIT_IDLE: remain until rx_s==1, then go to IDLE. A break condition never retriggers a frame.
- Sampling instants: the stop-bit sample occurs SyncStages + floor(N/2) + (DataBits+1)*N cycles after the rx pin falling edge.
- Holding register:
  - On a good stop sample, if d_valid==0 or d_ready==1 in the same cycle: d_out<=shift register and d_valid<=1 on the next edge. This is 1-cycle latency from the stop sample.
  - Otherwise the new byte is dropped, the old byte is kept and overrun pulses for one cycle.
  - Accept (d_valid&d_ready) with no new byte: d_valid<=0 next edge; d_out holds its value.
  - Simultaneous accept and new byte: d_valid stays 1 and d_out takes the new byte.
- Minimum prescaler is 1 (N=2). prescaler=0 is unsupported; the receiver treats it as 1.
- Counter width is 32 bits; N is computed without overflow (prescaler=FFFF_FFFF is unsupported).

Decomposition:
- Shared uart_pkg holds:
  - UartRxStateT enum;
  - DataBits default constant;
  - a helper constant for the half-bit shift.
- word comes from config_pkg, unchanged.
- One natural sub-module: sync_ff (SyncStages-deep, reset-to-1 synchronizer), reusable elsewhere.
- Top-level test pairs the existing uart (tx) -> uart_rx loopback.

Test Plan:
- prescaler=3 (N=4): drive frame 0x41 on rx. Then:
  - d_valid rises exactly 2+2+36+1=41 cycles after the falling edge;
  - d_out=0x41;
  - framing_err=0, overrun=0.
- Loopback: existing fifo+uart tx sends 0x41, 0x42, 0x43 with d_ready=1 and the same prescaler -> uart_rx delivers 0x41, 0x42, 0x43 in order with no flags.
- Glitch: rx low for 1 cycle with N=8 -> START rejects it; state returns to IDLE; no d_valid, no flags; busy high for at most 5 cycles.
- Framing: frame 0x55 with stop bit forced low, rx held low 3N further -> framing_err pulses once; d_valid stays 0; the next valid frame 0x43 is received correctly.
- Overrun: d_ready=0, send 0x41 then 0x42 -> d_out stays 0x41 and overrun pulses once at the second stop sample. Then set d_ready=1 with a third frame 0x43 completing in the same accept cycle -> d_out=0x43 and d_valid stays 1.
- Reset mid-frame: assert reset_i=0 during data bit 4 of 0x41, release, then send 0x42 -> all outputs 0 during reset; only 0x42 is delivered; no flags.
